sr_flag_bank_ctrl: RTL and testbench
====================================

Name: sr_flag_bank_ctrl

Overview:
Shared controller for a bank of NUM_FLAGS SR-style flag bits written by NUM_REQ independent requesters. Each requester submits one set/reset command (flag index, S, R) through a req/gnt handshake. A round-robin arbiter serialises the commands and applies standard SR semantics to the addressed flag. It reports illegal S=R=1 commands and out-of-range indices through an error pulse and a sticky error bit.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NUM_FLAGS, 8, number of SR flag bits in the bank (1..32)
IDX_W, $clog2(NUM_FLAGS) (min 1), width of one flag index

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester command valid; held until matching gnt
req_idx  input  NUM_REQ*IDX_W  per-requester flag index, requester i in bits [i*IDX_W +: IDX_W]
req_s  input  NUM_REQ  per-requester set bit
req_r  input  NUM_REQ  per-requester reset bit
gnt  output  NUM_REQ  one-hot, one-cycle completion pulse
busy  output  1  high when state is not IDLE
flags  output  NUM_FLAGS  flag bank Q
flags_bar  output  NUM_FLAGS  always ~flags
err  output  1  one-cycle pulse on an illegal command
err_sticky  output  1  set by err; cleared only by reset

Behaviour:
- Reset (async, mid-operation included):
  - state=IDLE; flags=0; flags_bar=all 1s; gnt=0; err=0; err_sticky=0.
  - RR pointer=0 (requester 0 has highest priority).
  - A command in flight is aborted: no gnt and no flag update.
- FSM states IDLE, APPLY, ACK:
  - IDLE: if any req bit is high, the RR arbiter picks a winner (search starts at the pointer). Latch the winner's id, idx, s and r, then go to APPLY. Otherwise stay in IDLE.
  - APPLY: update the addressed flag. SR=10 sets it to 1. SR=01 clears it to 0. SR=00 holds. SR=11 holds and pulses err. An idx >= NUM_FLAGS writes nothing and pulses err. Go to ACK.
  - ACK: gnt[winner]=1 for this cycle only. Pointer = (winner+1) mod NUM_REQ. Go to IDLE.
- Timing:
  - req sampled in cycle 0.
  - Flag update is visible and err pulses in cycle 2 (registered on the edge leaving APPLY).
  - gnt is high in cycle 2.
  - Earliest next arbitration is cycle 3.
- Throughput: one command per 3 cycles.
- Requester rules: hold req, idx, s and r stable until gnt. Deassert req the cycle after gnt, otherwise the command is re-arbitrated as a new command.
- Latching: the command is latched at arbitration, so input changes after that cycle are ignored.
- Arbitration: a newly arriving req is only considered in IDLE. Under full load the RR order guarantees every requester is served within NUM_REQ commands.
- err_sticky is set in the same cycle as err.
- flags_bar is combinationally ~flags; it is never equal to flags.

Optional Feature:
SR_FLAG_IRQ_EN
- When defined, adds two ports:
  - input irq_mask [NUM_FLAGS]
  - registered output irq: irq = |(flags & irq_mask) | err_sticky, updated one cycle after the flags change; reset value 0.
- When not defined, these ports and the logic are absent and all other behaviour is unchanged.

Decomposition:
- Package sr_flag_pkg holds:
  - state enum (ST_IDLE, ST_APPLY, ST_ACK)
  - SR command constants SR_HOLD=2'b00, SR_CLR=2'b01, SR_SET=2'b10, SR_ILLEGAL=2'b11
- Sub-module rr_arbiter:
  - parameter N
  - inputs req[N], ptr, advance
  - outputs one-hot grant and winner id; owns the pointer register.

Test Plan:
- Reset release, no req -> flags=8'h00, flags_bar=8'hFF, busy=0, gnt=0 for 10 cycles.
- Requester 1 sends idx=3, S=1, R=0 in cycle 0 -> busy=1 in cycle 1; flags=8'h08 and gnt=4'b0010 in cycle 2; busy=0 in cycle 3. Then idx=3, S=0, R=1 -> flags=8'h00.
- All 4 req high with idx 0..3 and S=1 -> gnt order 0,1,2,3, each 3 cycles apart; flags=8'h0F at the end.
- Requester 2 sends idx=5, S=1, R=1 with flags=8'h20 -> flags stays 8'h20; err pulses for 1 cycle; err_sticky=1 until reset; gnt[2] still pulses.
- NUM_FLAGS=6 with idx=7, S=1 -> flags unchanged, err pulse, gnt issued.
- Reset asserted in APPLY -> flags=0 immediately, no gnt, state IDLE. SR_FLAG_IRQ_EN build with irq_mask=8'h04 and flag 2 set -> irq=1 one cycle later.

Source files
------------

// File: rtl/sr_flag_pkg.sv
// Shared types and constants for the SR flag bank controller.
package sr_flag_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  // Command encoding is {S, R}.
  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_CLR     = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the stored pointer; pointer reloads from ptr on advance.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] winner,
  output logic            valid
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  int              pos;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = ptr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Walk from the farthest offset back to the pointer so the nearest requester wins last.
  always_comb begin
    grant  = '0;
    winner = '0;
    valid  = 1'b0;
    pos    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = (int'(ptr_q) + k) % N;
      if (req[pos]) begin
        grant  = N'(1) << pos;
        winner = ID_W'(pos);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_flag_bank_ctrl.sv
// Arbitrated SR flag bank: IDLE -> APPLY -> ACK per command, round-robin across requesters.
// Optional macro SR_FLAG_IRQ_EN adds irq_mask input and registered irq output.
module sr_flag_bank_ctrl
  import sr_flag_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_FLAGS = 8,
  parameter int IDX_W     = idx_width(NUM_FLAGS)
) (
  input  logic                     clock,
  input  logic                     reset,
`ifdef SR_FLAG_IRQ_EN
  input  logic [NUM_FLAGS-1:0]     irq_mask,
  output logic                     irq,
`endif
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  input  logic [NUM_REQ-1:0]       req_s,
  input  logic [NUM_REQ-1:0]       req_r,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic [NUM_FLAGS-1:0]     flags,
  output logic [NUM_FLAGS-1:0]     flags_bar,
  output logic                     err,
  output logic                     err_sticky
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      win_id_q, win_id_d;
  logic [NUM_REQ-1:0]   win_oh_q, win_oh_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [1:0]           cmd_q, cmd_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic                 err_q, err_d;
  logic                 err_sticky_q, err_sticky_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [ID_W-1:0]      arb_winner;
  logic                 arb_valid;
  logic                 arb_advance;
  logic [ID_W-1:0]      ptr_load;
  logic                 idx_oob;
  logic [NUM_FLAGS-1:0] flag_hit;

  assign ptr_load = (win_id_q == ID_W'(NUM_REQ - 1)) ? '0 : win_id_q + 1'b1;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .ptr     (ptr_load),
    .advance (arb_advance),
    .grant   (arb_grant),
    .winner  (arb_winner),
    .valid   (arb_valid)
  );

  // Index width may exceed the bank when NUM_FLAGS is not a power of two.
  assign idx_oob = (32'(idx_q) >= 32'(NUM_FLAGS));

  generate
    for (genvar gi = 0; gi < NUM_FLAGS; gi++) begin : g_hit
      assign flag_hit[gi] = !idx_oob && (idx_q == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    win_id_d    = win_id_q;
    win_oh_d    = win_oh_q;
    idx_d       = idx_q;
    cmd_d       = cmd_q;
    flags_d     = flags_q;
    err_d       = 1'b0;
    arb_advance = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          win_id_d = arb_winner;
          win_oh_d = arb_grant;
          idx_d    = req_idx[arb_winner*IDX_W +: IDX_W];
          cmd_d    = {req_s[arb_winner], req_r[arb_winner]};
          state_d  = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (idx_oob || (cmd_q == SR_ILLEGAL)) begin
          err_d = 1'b1;
        end else if (cmd_q == SR_SET) begin
          flags_d = flags_q | flag_hit;
        end else if (cmd_q == SR_CLR) begin
          flags_d = flags_q & ~flag_hit;
        end
        state_d = ST_ACK;
      end
      ST_ACK: begin
        arb_advance = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    err_sticky_d = err_sticky_q | err_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      win_id_q     <= '0;
      win_oh_q     <= '0;
      idx_q        <= '0;
      cmd_q        <= SR_HOLD;
      flags_q      <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_id_q     <= win_id_d;
      win_oh_q     <= win_oh_d;
      idx_q        <= idx_d;
      cmd_q        <= cmd_d;
      flags_q      <= flags_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign gnt        = (state_q == ST_ACK) ? win_oh_q : '0;
  assign busy       = (state_q != ST_IDLE);
  assign flags      = flags_q;
  assign flags_bar  = ~flags_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;

`ifdef SR_FLAG_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = |(flags_q & irq_mask) | err_sticky_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_sr_flag_bank_ctrl.sv
// Directed scoreboard bench for sr_flag_bank_ctrl (NUM_FLAGS=6 so out-of-range indices exist).
module tb_sr_flag_bank_ctrl;

  localparam int NR = 4;
  localparam int NF = 6;
  localparam int IW = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*IW-1:0]  req_idx;
  logic [NR-1:0]     req_s;
  logic [NR-1:0]     req_r;
  logic [NR-1:0]     gnt;
  logic              busy;
  logic [NF-1:0]     flags;
  logic [NF-1:0]     flags_bar;
  logic              err;
  logic              err_sticky;
`ifdef SR_FLAG_IRQ_EN
  logic [NF-1:0]     irq_mask;
  logic              irq;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [NR-1:0] g;
    logic [NF-1:0] f;
    logic          e;
  } exp_t;

  exp_t          sb[$];
  logic [NF-1:0] model_flags;

  sr_flag_bank_ctrl #(
    .NUM_REQ   (NR),
    .NUM_FLAGS (NF),
    .IDX_W     (IW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
`ifdef SR_FLAG_IRQ_EN
    .irq_mask   (irq_mask),
    .irq        (irq),
`endif
    .req        (req),
    .req_idx    (req_idx),
    .req_s      (req_s),
    .req_r      (req_r),
    .gnt        (gnt),
    .busy       (busy),
    .flags      (flags),
    .flags_bar  (flags_bar),
    .err        (err),
    .err_sticky (err_sticky)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every gnt pops the oldest expectation and checks the completion cycle.
  always @(negedge clock) begin
    if (reset === 1'b0 && gnt !== '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_gnt", 32'(gnt), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_gnt", 32'(gnt), 32'(e.g));
        chk("sb_flags", 32'(flags), 32'(e.f));
        chk("sb_err", 32'(err), 32'(e.e));
      end
    end
  end

  task automatic push_cmd(input int id, input int idx, input bit s, input bit r);
    exp_t e;
    req_idx[id*IW +: IW] = IW'(idx);
    req_s[id] = s;
    req_r[id] = r;
    req[id]   = 1'b1;
    if (idx >= NF || (s && r)) begin
      e.e = 1'b1;
    end else begin
      e.e = 1'b0;
      if (s) model_flags[idx] = 1'b1;
      else if (r) model_flags[idx] = 1'b0;
    end
    e.f = model_flags;
    e.g = NR'(1) << id;
    sb.push_back(e);
  endtask

  // Waits (bounded) for a gnt, then drops the granted req the cycle after.
  task automatic wait_gnt(output logic [NR-1:0] g, output int at);
    g  = '0;
    at = -1;
    for (int i = 0; i < 20 && g === '0; i++) begin
      @(negedge clock);
      if (gnt !== '0) begin
        g  = gnt;
        at = cyc;
      end
    end
    chk("gnt_timeout", 32'(g !== '0), 32'h1);
    @(posedge clock);
    #1;
    req = req & ~g;
  endtask

  task automatic do_reset();
    req = '0;
    reset = 1'b1;
    sb.delete();
    model_flags = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  logic [NR-1:0] g;
  int            t;
  int            t_prev;

  initial begin
    req = '0; req_idx = '0; req_s = '0; req_r = '0;
    model_flags = '0;
    g = '0; t = 0; t_prev = 0;
`ifdef SR_FLAG_IRQ_EN
    irq_mask = '0;
`endif
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("rst_flags", 32'(flags), 32'h00);
      chk("rst_flags_bar", 32'(flags_bar), 32'h3F);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_err", 32'({err, err_sticky}), 32'h0);
    end
    $display("step: reset idle done, checks=%0d", checks);

    // Single set with cycle-exact timing, then clear
    @(posedge clock);
    #1;
    push_cmd(1, 3, 1'b1, 1'b0);
    @(negedge clock);
    chk("c0_busy", 32'(busy), 32'h0);
    @(negedge clock);
    chk("c1_busy", 32'(busy), 32'h1);
    chk("c1_flags", 32'(flags), 32'h00);
    @(negedge clock);
    chk("c2_flags", 32'(flags), 32'h08);
    chk("c2_gnt", 32'(gnt), 32'h2);
    chk("c2_flags_bar", 32'(flags_bar), 32'h37);
    @(posedge clock);
    #1;
    req[1] = 1'b0;
    @(negedge clock);
    chk("c3_busy", 32'(busy), 32'h0);
    chk("c3_gnt", 32'(gnt), 32'h0);
    push_cmd(1, 3, 1'b0, 1'b1);
    wait_gnt(g, t);
    chk("clr_flags", 32'(flags), 32'h00);
    $display("step: set/clear requester 1 done, checks=%0d", checks);

    // Full load: round-robin order 0..3, three cycles apart
    do_reset();
    for (int k = 0; k < NR; k++) push_cmd(k, k, 1'b1, 1'b0);
    for (int k = 0; k < NR; k++) begin
      wait_gnt(g, t);
      chk("rr_order", 32'(g), 32'(NR'(1) << k));
      if (k > 0) chk("rr_spacing", 32'(t - t_prev), 32'd3);
      t_prev = t;
    end
    chk("rr_flags", 32'(flags), 32'h0F);
    $display("step: round-robin load done, checks=%0d", checks);

    // Illegal S=R=1
    do_reset();
    push_cmd(2, 5, 1'b1, 1'b0);
    wait_gnt(g, t);
    chk("pre_illegal_flags", 32'(flags), 32'h20);
    chk("pre_illegal_sticky", 32'(err_sticky), 32'h0);
    push_cmd(2, 5, 1'b1, 1'b1);
    wait_gnt(g, t);
    chk("illegal_gnt", 32'(g), 32'h4);
    @(negedge clock);
    chk("illegal_err_pulse_end", 32'(err), 32'h0);
    chk("illegal_sticky", 32'(err_sticky), 32'h1);
    chk("illegal_flags", 32'(flags), 32'h20);
    $display("step: illegal command done, checks=%0d", checks);

    // Out-of-range indices
    push_cmd(0, 7, 1'b1, 1'b0);
    wait_gnt(g, t);
    chk("oob7_gnt", 32'(g), 32'h1);
    push_cmd(3, 6, 1'b0, 1'b1);
    wait_gnt(g, t);
    chk("oob6_gnt", 32'(g), 32'h8);
    chk("oob_flags", 32'(flags), 32'h20);
    chk("oob_sticky", 32'(err_sticky), 32'h1);
    $display("step: out-of-range done, checks=%0d", checks);

    // Async reset while in APPLY aborts the command
    push_cmd(3, 0, 1'b1, 1'b0);
    @(posedge clock);
    #2;
    chk("apply_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("arst_flags", 32'(flags), 32'h00);
    chk("arst_flags_bar", 32'(flags_bar), 32'h3F);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_sticky", 32'(err_sticky), 32'h0);
    req = '0;
    sb.delete();
    model_flags = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("post_arst_gnt", 32'(gnt), 32'h0);
      chk("post_arst_flags", 32'(flags), 32'h00);
    end
    $display("step: async reset in APPLY done, checks=%0d", checks);

`ifdef SR_FLAG_IRQ_EN
    irq_mask = 6'h04;
    @(negedge clock);
    chk("irq_idle", 32'(irq), 32'h0);
    @(posedge clock);
    #1;
    push_cmd(1, 2, 1'b1, 1'b0);
    repeat (3) @(negedge clock);
    chk("irq_same_cycle", 32'(irq), 32'h0);
    @(negedge clock);
    chk("irq_next_cycle", 32'(irq), 32'h1);
    req[1] = 1'b0;
    $display("step: irq done, checks=%0d", checks);
`endif

    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
